// File: rtl/multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_shifter
// Description : Iterative 32-bit (parameterisable) log shifter. One log stage
//               is applied per clock, selected by successive bits of the
//               latched shift amount, LSB first. Supports SLL, SRL, SRA and
//               ROTR. Latency is fixed at SHAMT_W cycles after accept,
//               independent of the shift amount.
//
// Ports       : clock        - system clock, rising edge
//               reset        - synchronous, active-high reset
//               start        - request; accepted only in IDLE or DONE
//               data_in      - operand, sampled at accept
//               shift_amount - shift distance, sampled at accept
//               shift_op     - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//               busy         - high while stages are being applied
//               done         - one-cycle pulse, data_out valid from here
//               data_out     - result register
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_shifter #(
    parameter int width   = 32,
    parameter int SHAMT_W = $clog2(width)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [width-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shift_amount,
    input  logic [1:0]         shift_op,
    output logic               busy,
    output logic               done,
    output logic [width-1:0]   data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]         c_OP_SLL     = 2'b00;
    localparam logic [1:0]         c_OP_SRL     = 2'b01;
    localparam logic [1:0]         c_OP_SRA     = 2'b10;
    localparam logic [1:0]         c_OP_ROTR    = 2'b11;
    localparam logic [SHAMT_W-1:0] c_LAST_STAGE = SHAMT_W'(SHAMT_W - 1);
    localparam logic [SHAMT_W-1:0] c_K_ONE      = SHAMT_W'(1);
    // One extra bit so that the full width (rotate complement) is representable.
    localparam logic [SHAMT_W:0]   c_WIDTH      = (SHAMT_W + 1)'(width);
    localparam logic [SHAMT_W:0]   c_DIST_ONE   = (SHAMT_W + 1)'(1);

    state_t             r_state;
    logic [width-1:0]   r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_k;

    logic [SHAMT_W:0]   w_dist;
    logic [SHAMT_W:0]   w_rdist;
    logic [width-1:0]   w_stage;
    logic [width-1:0]   w_next;

    // Stage k moves the working value by 2^k. The largest stage distance is
    // width/2, so the rotate complement (width - 2^k) never reaches zero.
    assign w_dist  = c_DIST_ONE << r_k;
    assign w_rdist = c_WIDTH - w_dist;

    always_comb begin
        w_stage = r_work;
        case (r_op)
            c_OP_SLL:  w_stage = r_work << w_dist;
            c_OP_SRL:  w_stage = r_work >> w_dist;
            // Sign is taken from the working value at this stage, which is
            // the same as the original sign since earlier SRA stages keep it.
            c_OP_SRA:  w_stage = width'($signed(r_work) >>> w_dist);
            c_OP_ROTR: w_stage = (r_work >> w_dist) | (r_work << w_rdist);
            default:   w_stage = r_work;
        endcase
        // A zero amount bit holds the value; the stage still costs a cycle so
        // latency never depends on the data.
        w_next = r_amt[r_k] ? w_stage : r_work;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_amt    <= '0;
            r_op     <= '0;
            r_k      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // done is a single-cycle pulse; any cycle spent here
                    // after DONE clears it.
                    done <= 1'b0;
                    if (start) begin
                        r_work  <= data_in;
                        r_amt   <= shift_amount;
                        r_op    <= shift_op;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    // start is deliberately not looked at here: an in-flight
                    // operation cannot be disturbed by a new request.
                    r_work <= w_next;
                    r_k    <= r_k + c_K_ONE;
                    if (r_k == c_LAST_STAGE) begin
                        data_out <= w_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_shifter
// Description : Self-checking bench for multicycle_shifter. Directed cases
//               plus random operations compared against a whole-shift
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clock;
    logic          reset;
    logic          start;
    logic [W-1:0]  data_in;
    logic [SW-1:0] shift_amount;
    logic [1:0]    shift_op;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;

    int n_checks;
    int n_fail;

    multicycle_shifter #(.width(W), .SHAMT_W(SW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .shift_op     (shift_op),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: the whole shift in one step, straight from the op definitions.
    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input logic [SW-1:0] a,
                                           input logic [1:0] op);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        case (op)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = W'($signed(d) >>> a);
            default: begin
                dd = {d, d} >> a;
                r  = dd[W-1:0];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
    // one cycle after the done pulse.
    task automatic run_op(input string tag, input logic [W-1:0] d, input logic [SW-1:0] a,
                          input logic [1:0] op, input logic [W-1:0] exp);
        start = 1'b1; data_in = d; shift_amount = a; shift_op = op;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < SW; i++) begin
            check({tag, "_busy"}, W'(busy), W'(1));
            check({tag, "_nodone"}, W'(done), W'(0));
            @(negedge clock);
        end
        check({tag, "_done_busy"}, W'(busy), W'(0));
        check({tag, "_done"}, W'(done), W'(1));
        check({tag, "_result"}, data_out, exp);
        @(negedge clock);
        check({tag, "_pulse_end"}, W'(done), W'(0));
        check({tag, "_hold"}, data_out, exp);
    endtask

    initial begin
        logic [W-1:0]  rd;
        logic [SW-1:0] ra;
        logic [1:0]    rop;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; data_in = '0; shift_amount = '0; shift_op = '0;
        repeat (3) @(negedge clock);

        // Reset values, including reset winning over a simultaneous start.
        start = 1'b1; data_in = 32'hDEADBEEF; shift_amount = 5'd3;
        @(negedge clock);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_dout", data_out, '0);
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
        check("idle_busy", W'(busy), W'(0));

        // Directed cases.
        run_op("sll31",  32'h00000001, 5'd31, 2'b00, 32'h80000000);
        run_op("srl28",  32'hF0000000, 5'd28, 2'b01, 32'h0000000F);
        run_op("sra28",  32'hF0000000, 5'd28, 2'b10, 32'hFFFFFFFF);
        run_op("sra4",   32'h80000000, 5'd4,  2'b10, 32'hF8000000);
        run_op("rotr8",  32'h12345678, 5'd8,  2'b11, 32'h78123456);
        run_op("zero00", 32'hA5C3_0F96, 5'd0, 2'b00, 32'hA5C30F96);
        run_op("zero01", 32'h8000_0001, 5'd0, 2'b01, 32'h80000001);
        run_op("zero10", 32'h8765_4321, 5'd0, 2'b10, 32'h87654321);
        run_op("zero11", 32'h1357_9BDF, 5'd0, 2'b11, 32'h13579BDF);

        // start pulsed mid-SHIFT is ignored; start held in DONE is accepted.
        start = 1'b1; data_in = 32'h0000_00F0; shift_amount = 5'd4; shift_op = 2'b00;
        @(negedge clock);
        check("mid_busy1", W'(busy), W'(1));
        data_in = 32'hFFFF_FFFF; shift_amount = 5'd17; shift_op = 2'b11;
        @(negedge clock);
        start = 1'b0;
        check("mid_busy2", W'(busy), W'(1));
        for (int i = 0; i < SW - 2; i++) begin
            @(negedge clock);
            check("mid_busy", W'(busy), W'(1));
            check("mid_nodone", W'(done), W'(0));
        end
        @(negedge clock);
        check("mid_done", W'(done), W'(1));
        check("mid_result", data_out, 32'h00000F00);
        start = 1'b1; data_in = 32'h0000_0F00; shift_amount = 5'd8; shift_op = 2'b01;
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", W'(busy), W'(1));
        check("b2b_nodone", W'(done), W'(0));
        check("b2b_dout_hold", data_out, 32'h00000F00);
        for (int i = 0; i < SW - 1; i++) begin
            @(negedge clock);
            check("b2b_busy_n", W'(busy), W'(1));
        end
        @(negedge clock);
        check("b2b_done", W'(done), W'(1));
        check("b2b_result", data_out, 32'h0000000F);
        @(negedge clock);
        check("b2b_pulse_end", W'(done), W'(0));

        // Reset in the third SHIFT cycle abandons the operation.
        start = 1'b1; data_in = 32'h1234_5678; shift_amount = 5'd1; shift_op = 2'b00;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rmid_busy_pre", W'(busy), W'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rmid_busy", W'(busy), W'(0));
        check("rmid_done", W'(done), W'(0));
        check("rmid_dout", data_out, '0);
        for (int i = 0; i < 2 * SW; i++) begin
            @(negedge clock);
            check("rmid_no_done", W'(done), W'(0));
            check("rmid_no_busy", W'(busy), W'(0));
        end
        run_op("after_rst", 32'h1234_5678, 5'd1, 2'b00, 32'h2468ACF0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rd  = W'($urandom);
            ra  = SW'($urandom_range(0, W - 1));
            rop = 2'($urandom_range(0, 3));
            run_op("rand", rd, ra, rop, model(rd, ra, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
